// File: rtl/mem_line_deserializer_if.sv
// Handshake bundle for the wide-line to narrow-beat deserializer.
// master drives lines in and takes beats out; slave is the deserializer itself.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface mem_line_deserializer_if #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [`DATA_WIDTH*IN_WIDTH-1:0]  in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [`DATA_WIDTH*OUT_WIDTH-1:0] out_data;
  logic                             out_last;
  logic [IDX_W-1:0]                 out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );
endinterface

// File: rtl/mem_line_deserializer.sv
// Holds one IN_WIDTH-word line and emits it as RATIO beats of OUT_WIDTH words,
// lowest words first; the next line can be taken in the cycle the last beat leaves.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_line_deserializer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_line_deserializer_if.slave   bus
);
  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LINE_W = `DATA_WIDTH * IN_WIDTH;
  localparam int BEAT_W = `DATA_WIDTH * OUT_WIDTH;

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_multiple
    $error("IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (OUT_WIDTH > IN_WIDTH) begin : g_bad_order
    $error("OUT_WIDTH must not exceed IN_WIDTH");
  end

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   w_line_shift;
  logic [IDX_W-1:0]    r_idx;
  logic                w_last;
  logic                w_in_hs;
  logic                w_advance;

  // The current beat always sits in the low bits; each accepted beat shifts the next one down.
  if (RATIO > 1) begin : g_shift
    assign w_line_shift = {{BEAT_W{1'b0}}, r_line[LINE_W-1:BEAT_W]};
  end else begin : g_no_shift
    assign w_line_shift = r_line;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid) w_state_nxt = S_SEND;
      S_SEND: if (bus.out_ready && w_last && !bus.in_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_last        = (r_state == S_SEND) && (r_idx == IDX_W'(RATIO - 1));
    bus.out_valid = (r_state == S_SEND);
    bus.out_last  = w_last;
    bus.out_idx   = r_idx;
    bus.out_data  = r_line[BEAT_W-1:0];
    bus.in_ready  = (r_state == S_IDLE) || (bus.out_ready && w_last);
  end

  assign w_in_hs   = bus.in_valid && bus.in_ready;
  assign w_advance = bus.out_valid && bus.out_ready && !w_last;

  // NOTE: the line register is reset (not left undefined) so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_idx  <= '0;
    end else if (w_in_hs) begin
      r_line <= bus.in_data;
      r_idx  <= '0;
    end else if (w_advance) begin
      r_line <= w_line_shift;
      r_idx  <= r_idx + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_line_deserializer.sv
// Randomized and directed bench for mem_line_deserializer: a beat-queue model
// predicts every output cycle for a 256/32 instance and a 32/32 pass-through instance.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_mem_line_deserializer;
  localparam int DW     = `DATA_WIDTH;
  localparam int LINE_W = DW * 256;
  localparam int BEAT_W = DW * 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_line_deserializer_if #(.IN_WIDTH(256), .OUT_WIDTH(32)) u_if ();
  mem_line_deserializer_if #(.IN_WIDTH(32),  .OUT_WIDTH(32)) u_if1 ();

  mem_line_deserializer #(.IN_WIDTH(256), .OUT_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave)
  );
  mem_line_deserializer #(.IN_WIDTH(32), .OUT_WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Model: every accepted line becomes a list of pending beats, oldest first.
  typedef struct {
    logic [BEAT_W-1:0] data;
    int                idx;
    bit                last;
  } beat_t;

  beat_t             q[$];
  logic [BEAT_W-1:0] q1[$];
  int                n_out0 = 0;
  int                n_out1 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid",    u_if.out_valid, 0);
      check("rst_last",     u_if.out_last,  0);
      check("rst_idx",      u_if.out_idx,   0);
      check("rst_data",     u_if.out_data,  0);
      check("rst_in_ready", u_if.in_ready,  1);
      check("rst1_valid",   u_if1.out_valid, 0);
      check("rst1_in_ready", u_if1.in_ready, 1);
      q.delete();
      q1.delete();
    end else begin
      if (q.size() == 0) begin
        check("idle_valid", u_if.out_valid, 0);
        check("idle_ready", u_if.in_ready,  1);
      end else begin
        check("beat_valid", u_if.out_valid, 1);
        check("beat_data",  u_if.out_data,  q[0].data);
        check("beat_idx",   u_if.out_idx,   q[0].idx);
        check("beat_last",  u_if.out_last,  q[0].last);
        check("send_ready", u_if.in_ready,  q[0].last && u_if.out_ready);
      end
      if (u_if.out_valid && u_if.out_ready) begin
        n_out0++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (u_if.in_valid && u_if.in_ready) begin
        for (int k = 0; k < 8; k++) begin
          beat_t b;
          b.data = u_if.in_data[k*BEAT_W +: BEAT_W];
          b.idx  = k;
          b.last = (k == 7);
          q.push_back(b);
        end
      end

      if (q1.size() == 0) begin
        check("idle1_valid", u_if1.out_valid, 0);
        check("idle1_ready", u_if1.in_ready,  1);
      end else begin
        check("beat1_valid", u_if1.out_valid, 1);
        check("beat1_data",  u_if1.out_data,  q1[0]);
        check("beat1_idx",   u_if1.out_idx,   0);
        check("beat1_last",  u_if1.out_last,  1);
        check("send1_ready", u_if1.in_ready,  u_if1.out_ready);
      end
      if (u_if1.out_valid && u_if1.out_ready) begin
        n_out1++;
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (u_if1.in_valid && u_if1.in_ready) q1.push_back(u_if1.in_data);
    end
  end

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int g = 0; g < 256; g++) l[g*DW +: DW] = DW'($urandom);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] pattern_line(input bit reverse);
    logic [LINE_W-1:0] l;
    for (int g = 0; g < 256; g++) l[g*DW +: DW] = reverse ? DW'(255 - g) : DW'(g);
    return l;
  endfunction

  task automatic send_line(input logic [LINE_W-1:0] d);
    bit acc = 0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (u_if.in_ready) acc = 1;
    end
    check("send_accept", acc, 1);
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  task automatic send_line1(input logic [BEAT_W-1:0] d);
    bit acc = 0;
    u_if1.in_valid = 1'b1;
    u_if1.in_data  = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (u_if1.in_ready) acc = 1;
    end
    check("send1_accept", acc, 1);
    @(posedge clk); #1;
    u_if1.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (q.size() != 0 || q1.size() != 0); i++) begin
      @(negedge clk); #1;
    end
    check("drain", q.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int pat [17] = '{0,0,0,1,1,1,1,0,0,0,1,1,1,0,0,0,1};

    u_if.in_valid   = 1'b0;
    u_if.in_data    = '0;
    u_if.out_ready  = 1'b0;
    u_if1.in_valid  = 1'b0;
    u_if1.in_data   = '0;
    u_if1.out_ready = 1'b0;

    // Reset, then idle with in_valid low.
    #2 rst_n = 1'b0;
    #20;
    check("t1_in_ready", u_if.in_ready,  1);
    check("t1_valid",    u_if.out_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("t1_idle", u_if.out_valid, 0);

    // Single counting line.
    u_if.out_ready = 1'b1;
    base = n_out0;
    send_line(pattern_line(0));
    wait_drain();
    check("t2_beats", n_out0 - base, 8);
    check("t2_after", u_if.out_valid, 0);

    // Two lines back to back.
    base = n_out0;
    send_line(pattern_line(0));
    send_line(pattern_line(1));
    wait_drain();
    check("t3_beats", n_out0 - base, 16);

    // Backpressure at beats 0, 4 and 7.
    u_if.out_ready = 1'b0;
    base = n_out0;
    send_line(rand_line());
    for (int c = 0; c < 17; c++) begin
      u_if.out_ready = pat[c][0];
      @(posedge clk); #1;
    end
    u_if.out_ready = 1'b1;
    wait_drain();
    check("t4_beats", n_out0 - base, 8);

    // Reset after beat 3 has been accepted.
    send_line(rand_line());
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_valid",    u_if.out_valid, 0);
    check("t5_idx",      u_if.out_idx,   0);
    check("t5_in_ready", u_if.in_ready,  1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_out0;
    send_line(rand_line());
    wait_drain();
    check("t5_beats", n_out0 - base, 8);

    // Random traffic on the 8:1 instance.
    for (int c = 0; c < 300; c++) begin
      u_if.in_valid  = ($urandom_range(0, 2) == 0);
      u_if.in_data   = rand_line();
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    wait_drain();

    // Ratio 1: three lines back to back.
    u_if1.out_ready = 1'b1;
    base = n_out1;
    for (int i = 0; i < 3; i++) send_line1(BEAT_W'(rand_line()));
    wait_drain();
    check("t6_beats", n_out1 - base, 3);

    // Random traffic on the pass-through instance.
    for (int c = 0; c < 150; c++) begin
      u_if1.in_valid  = $urandom_range(0, 1) == 1;
      u_if1.in_data   = BEAT_W'(rand_line());
      u_if1.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    u_if1.in_valid  = 1'b0;
    u_if1.out_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
